// File: rtl/lower_memory_arbiter.sv
// Round-robin arbiter sharing one hold-until-RDY lower-memory port among
// NUM_PORTS domain-controller lower-side requesters, one access at a time.
module lower_memory_arbiter #(
    parameter int NUM_PORTS  = 2,
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter int MASK_WIDTH = 4
) (
    input  logic                             CLK,
    input  logic                             RST,
    input  logic [NUM_PORTS*ADDR_WIDTH-1:0]  REQ_ADDR,
    input  logic [NUM_PORTS-1:0]             REQ_RE,
    input  logic [NUM_PORTS-1:0]             REQ_WE,
    input  logic [NUM_PORTS*DATA_WIDTH-1:0]  REQ_D,
    input  logic [NUM_PORTS*MASK_WIDTH-1:0]  REQ_MASK,
    output logic [NUM_PORTS*DATA_WIDTH-1:0]  REQ_Q,
    output logic [NUM_PORTS-1:0]             REQ_RDY,
    output logic [NUM_PORTS-1:0]             REQ_INIT_DONE,
    output logic [ADDR_WIDTH-1:0]            MEM_ADDR,
    output logic                             MEM_RE,
    output logic                             MEM_WE,
    output logic [DATA_WIDTH-1:0]            MEM_D,
    output logic [MASK_WIDTH-1:0]            MEM_MASK,
    input  logic [DATA_WIDTH-1:0]            MEM_Q,
    input  logic                             MEM_RDY,
    input  logic                             MEM_INIT_DONE,
    output logic                             BUSY
);

    localparam int PW = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        RESP  = 2'd2
    } state_t;

    state_t                          state_q, state_d;
    logic [PW-1:0]                   last_q, last_d;
    logic [PW-1:0]                   grant_q, grant_d;
    logic [ADDR_WIDTH-1:0]           addr_q, addr_d;
    logic [DATA_WIDTH-1:0]           data_q, data_d;
    logic [MASK_WIDTH-1:0]           mask_q, mask_d;
    logic                            re_q, re_d;
    logic                            we_q, we_d;
    logic [NUM_PORTS*DATA_WIDTH-1:0] q_q, q_d;
    logic [NUM_PORTS-1:0]            rdy_q, rdy_d;
    logic                            busy_q, busy_d;

    logic [NUM_PORTS-1:0]            pending_s;
    logic [PW-1:0]                   winner_s;

    // First pending port scanning upward from last+1 with wrap; the port
    // just served is therefore examined last.
    function automatic logic [PW-1:0] pick_winner(
        input logic [NUM_PORTS-1:0] pend,
        input logic [PW-1:0]        last
    );
        logic [PW-1:0] win;
        logic [PW-1:0] idx_v;
        logic          found;
        int            idx;
        win   = last;
        found = 1'b0;
        for (int off = 1; off <= NUM_PORTS; off++) begin
            idx   = (int'(last) + off) % NUM_PORTS;
            idx_v = PW'(idx);
            if (!found && pend[idx_v]) begin
                win   = idx_v;
                found = 1'b1;
            end else begin
                found = found;
            end
        end
        return win;
    endfunction

    assign pending_s     = REQ_RE | REQ_WE;
    assign winner_s      = pick_winner(pending_s, last_q);
    assign REQ_INIT_DONE = {NUM_PORTS{MEM_INIT_DONE}};

    assign MEM_ADDR = addr_q;
    assign MEM_D    = data_q;
    assign MEM_MASK = mask_q;
    assign MEM_RE   = re_q;
    assign MEM_WE   = we_q;
    assign REQ_Q    = q_q;
    assign REQ_RDY  = rdy_q;
    assign BUSY     = busy_q;

    // Next-state and datapath: latch the winner in IDLE, wait for MEM_RDY
    // in ISSUE, pulse the winner's REQ_RDY in RESP.
    always_comb begin
        state_d = state_q;
        last_d  = last_q;
        grant_d = grant_q;
        addr_d  = addr_q;
        data_d  = data_q;
        mask_d  = mask_q;
        re_d    = re_q;
        we_d    = we_q;
        q_d     = q_q;
        rdy_d   = '0;
        case (state_q)
            IDLE: begin
                if (MEM_INIT_DONE && (|pending_s)) begin
                    grant_d = winner_s;
                    re_d    = REQ_RE[winner_s];
                    we_d    = REQ_WE[winner_s];
                    for (int i = 0; i < NUM_PORTS; i++) begin
                        if (winner_s == PW'(i)) begin
                            addr_d = REQ_ADDR[i*ADDR_WIDTH +: ADDR_WIDTH];
                            data_d = REQ_D[i*DATA_WIDTH +: DATA_WIDTH];
                            mask_d = REQ_MASK[i*MASK_WIDTH +: MASK_WIDTH];
                        end else begin
                            addr_d = addr_d;
                        end
                    end
                    state_d = ISSUE;
                end else begin
                    state_d = IDLE;
                end
            end
            ISSUE: begin
                if (MEM_RDY) begin
                    for (int i = 0; i < NUM_PORTS; i++) begin
                        if (grant_q == PW'(i)) begin
                            rdy_d[i] = 1'b1;
                            if (re_q) begin
                                q_d[i*DATA_WIDTH +: DATA_WIDTH] = MEM_Q;
                            end else begin
                                q_d = q_d;
                            end
                        end else begin
                            rdy_d[i] = 1'b0;
                        end
                    end
                    re_d    = 1'b0;
                    we_d    = 1'b0;
                    state_d = RESP;
                end else begin
                    state_d = ISSUE;
                end
            end
            RESP: begin
                last_d  = grant_q;
                state_d = IDLE;
            end
            default: begin
                re_d    = 1'b0;
                we_d    = 1'b0;
                state_d = IDLE;
            end
        endcase
        busy_d = (state_d != IDLE);
    end

    // State and output registers; RST abandons any in-flight access.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q <= IDLE;
            last_q  <= PW'(NUM_PORTS - 1);
            grant_q <= '0;
            addr_q  <= '0;
            data_q  <= '0;
            mask_q  <= '0;
            re_q    <= 1'b0;
            we_q    <= 1'b0;
            q_q     <= '0;
            rdy_q   <= '0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            last_q  <= last_d;
            grant_q <= grant_d;
            addr_q  <= addr_d;
            data_q  <= data_d;
            mask_q  <= mask_d;
            re_q    <= re_d;
            we_q    <= we_d;
            q_q     <= q_d;
            rdy_q   <= rdy_d;
            busy_q  <= busy_d;
        end
    end

endmodule

// File: tb/tb_lower_memory_arbiter.sv
// Directed bench for lower_memory_arbiter (2 ports, 32-bit address/data).
module tb_lower_memory_arbiter;

    logic        CLK;
    logic        RST;
    logic [63:0] REQ_ADDR;
    logic [1:0]  REQ_RE;
    logic [1:0]  REQ_WE;
    logic [63:0] REQ_D;
    logic [7:0]  REQ_MASK;
    logic [63:0] REQ_Q;
    logic [1:0]  REQ_RDY;
    logic [1:0]  REQ_INIT_DONE;
    logic [31:0] MEM_ADDR;
    logic        MEM_RE;
    logic        MEM_WE;
    logic [31:0] MEM_D;
    logic [3:0]  MEM_MASK;
    logic [31:0] MEM_Q;
    logic        MEM_RDY;
    logic        MEM_INIT_DONE;
    logic        BUSY;

    int n_pass;
    int n_total;
    logic [31:0] exp_q [2];

    lower_memory_arbiter dut (
        .CLK(CLK), .RST(RST),
        .REQ_ADDR(REQ_ADDR), .REQ_RE(REQ_RE), .REQ_WE(REQ_WE),
        .REQ_D(REQ_D), .REQ_MASK(REQ_MASK), .REQ_Q(REQ_Q),
        .REQ_RDY(REQ_RDY), .REQ_INIT_DONE(REQ_INIT_DONE),
        .MEM_ADDR(MEM_ADDR), .MEM_RE(MEM_RE), .MEM_WE(MEM_WE),
        .MEM_D(MEM_D), .MEM_MASK(MEM_MASK), .MEM_Q(MEM_Q),
        .MEM_RDY(MEM_RDY), .MEM_INIT_DONE(MEM_INIT_DONE), .BUSY(BUSY)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_total++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    initial begin
        n_pass = 0;
        n_total = 0;
        RST = 1'b1;
        REQ_ADDR = '0; REQ_RE = '0; REQ_WE = '0; REQ_D = '0; REQ_MASK = '0;
        MEM_Q = '0; MEM_RDY = 1'b0; MEM_INIT_DONE = 1'b0;
        tick(); tick();
        RST = 1'b0;
        chk("rst_mem_re", {63'd0, MEM_RE}, 64'd0);
        chk("rst_mem_we", {63'd0, MEM_WE}, 64'd0);
        chk("rst_busy", {63'd0, BUSY}, 64'd0);
        chk("rst_rdy", {62'd0, REQ_RDY}, 64'd0);
        chk("rst_q", REQ_Q, 64'd0);
        chk("rst_addr", {32'd0, MEM_ADDR}, 64'd0);

        // Single read on port 0, memory answers in the second ISSUE cycle
        MEM_INIT_DONE = 1'b1;
        REQ_RE = 2'b01;
        REQ_ADDR[31:0] = 32'h0000_0100;
        tick();
        chk("rd_mem_re1", {63'd0, MEM_RE}, 64'd1);
        chk("rd_mem_we", {63'd0, MEM_WE}, 64'd0);
        chk("rd_addr", {32'd0, MEM_ADDR}, 64'h100);
        chk("rd_busy", {63'd0, BUSY}, 64'd1);
        REQ_ADDR[31:0] = 32'h0000_0999;
        tick();
        chk("rd_mem_re2", {63'd0, MEM_RE}, 64'd1);
        chk("rd_addr_held", {32'd0, MEM_ADDR}, 64'h100);
        chk("rd_rdy_early", {62'd0, REQ_RDY}, 64'd0);
        REQ_ADDR[31:0] = 32'h0000_0100;
        MEM_RDY = 1'b1;
        MEM_Q = 32'hDEAD_BEEF;
        tick();
        MEM_RDY = 1'b0;
        chk("rd_rdy", {62'd0, REQ_RDY}, 64'b01);
        chk("rd_q0", {32'd0, REQ_Q[31:0]}, 64'hDEAD_BEEF);
        chk("rd_q1", {32'd0, REQ_Q[63:32]}, 64'd0);
        chk("rd_mem_re_off", {63'd0, MEM_RE}, 64'd0);
        REQ_RE = 2'b00;
        tick();
        chk("rd_rdy_once", {62'd0, REQ_RDY}, 64'd0);
        chk("rd_idle", {63'd0, BUSY}, 64'd0);

        // Masked write on port 1, immediate completion
        REQ_WE = 2'b10;
        REQ_ADDR[63:32] = 32'h0000_0020;
        REQ_D[63:32] = 32'h1234_5678;
        REQ_MASK[7:4] = 4'b0101;
        tick();
        chk("wr_mem_we", {63'd0, MEM_WE}, 64'd1);
        chk("wr_mem_re", {63'd0, MEM_RE}, 64'd0);
        chk("wr_addr", {32'd0, MEM_ADDR}, 64'h20);
        chk("wr_d", {32'd0, MEM_D}, 64'h1234_5678);
        chk("wr_mask", {60'd0, MEM_MASK}, 64'b0101);
        MEM_RDY = 1'b1;
        MEM_Q = 32'h5555_AAAA;
        tick();
        MEM_RDY = 1'b0;
        chk("wr_rdy", {62'd0, REQ_RDY}, 64'b10);
        chk("wr_q", REQ_Q, {32'd0, 32'hDEAD_BEEF});
        chk("wr_mem_we_off", {63'd0, MEM_WE}, 64'd0);
        REQ_WE = 2'b00;
        tick();
        chk("wr_rdy_once", {62'd0, REQ_RDY}, 64'd0);

        // Contention after reset: both ports held pending -> 0,1,0,1
        RST = 1'b1;
        tick();
        RST = 1'b0;
        chk("rst2_q", REQ_Q, 64'd0);
        exp_q[0] = 32'd0;
        exp_q[1] = 32'd0;
        REQ_RE = 2'b11;
        REQ_ADDR = {32'h0000_00B0, 32'h0000_00A0};
        for (int k = 0; k < 4; k++) begin
            tick();
            chk("ct_addr", {32'd0, MEM_ADDR}, (k % 2 == 0) ? 64'hA0 : 64'hB0);
            MEM_RDY = 1'b1;
            MEM_Q = 32'h0000_1000 + 32'(k);
            exp_q[k % 2] = 32'h0000_1000 + 32'(k);
            tick();
            MEM_RDY = 1'b0;
            chk("ct_rdy", {62'd0, REQ_RDY}, (k % 2 == 0) ? 64'b01 : 64'b10);
            chk("ct_q", REQ_Q, {exp_q[1], exp_q[0]});
            if (k == 3) begin
                REQ_RE = 2'b00;
            end
            tick();
            chk("ct_rdy_idle", {62'd0, REQ_RDY}, 64'd0);
        end

        // Init gating: no grant while memory is not initialised
        MEM_INIT_DONE = 1'b0;
        REQ_RE = 2'b01;
        REQ_ADDR[31:0] = 32'h0000_0300;
        for (int c = 0; c < 10; c++) begin
            tick();
            chk("ig_mem_re", {63'd0, MEM_RE}, 64'd0);
            chk("ig_busy", {63'd0, BUSY}, 64'd0);
            chk("ig_init", {62'd0, REQ_INIT_DONE}, 64'd0);
        end
        MEM_INIT_DONE = 1'b1;
        #1;
        chk("ig_init_on", {62'd0, REQ_INIT_DONE}, 64'b11);
        tick();
        chk("ig_mem_re_on", {63'd0, MEM_RE}, 64'd1);
        chk("ig_addr", {32'd0, MEM_ADDR}, 64'h300);

        // Reset while ISSUE is waiting for MEM_RDY
        RST = 1'b1;
        tick();
        RST = 1'b0;
        REQ_RE = 2'b00;
        chk("rm_mem_re", {63'd0, MEM_RE}, 64'd0);
        chk("rm_rdy", {62'd0, REQ_RDY}, 64'd0);
        chk("rm_busy", {63'd0, BUSY}, 64'd0);
        chk("rm_addr", {32'd0, MEM_ADDR}, 64'd0);
        MEM_RDY = 1'b1;
        MEM_Q = 32'hBAD0_BAD0;
        tick();
        MEM_RDY = 1'b0;
        chk("rm_late_rdy", {62'd0, REQ_RDY}, 64'd0);
        chk("rm_late_q", REQ_Q, 64'd0);
        chk("rm_late_busy", {63'd0, BUSY}, 64'd0);

        // Port 1 read with MEM_RDY in the first ISSUE cycle
        REQ_RE = 2'b10;
        REQ_ADDR[63:32] = 32'h0000_0440;
        tick();
        chk("im_mem_re", {63'd0, MEM_RE}, 64'd1);
        chk("im_addr", {32'd0, MEM_ADDR}, 64'h440);
        MEM_RDY = 1'b1;
        MEM_Q = 32'hCAFE_F00D;
        tick();
        MEM_RDY = 1'b0;
        chk("im_mem_re_off", {63'd0, MEM_RE}, 64'd0);
        chk("im_rdy", {62'd0, REQ_RDY}, 64'b10);
        chk("im_q", REQ_Q, {32'hCAFE_F00D, 32'd0});
        REQ_RE = 2'b00;
        tick();
        chk("im_idle", {63'd0, BUSY}, 64'd0);
        chk("im_rdy_once", {62'd0, REQ_RDY}, 64'd0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
